// File: rtl/ekf_stage_seq.sv
// ekf_stage_seq
// Step sequencer in front of the RSA/NonLinear pair. Buffers observations
// from the PS in an 8-deep first-word-fall-through FIFO. A step_go pulse
// latches one motion command. The block then walks the RSA stage handshake:
// an optional PRD stage, then one NEW/UPD stage for each observation that was
// buffered when step_go arrived. Operands are held steady for each stage.
// A watchdog aborts any stage that gets no stage_rdy in time.
//
// Ports
//   clk, sys_rst              clock, synchronous active-high reset
//   step_go, prd_en           start-step pulse; run PRD first when prd_en=1
//   vlr, alpha                motion command, sampled with step_go
//   obs_valid/obs_ready       observation push handshake (ready = FIFO not full)
//   obs_rk, obs_phi, obs_new  observation payload (obs_new: 1 = NEW, 0 = UPD)
//   obs_count                 FIFO occupancy
//   busy, step_done           not-IDLE flag; one-cycle normal-completion pulse
//   err_timeout               sticky watchdog flag
//   stage_val, stage_rdy      RSA handshake (000 idle, 001 PRD, 010 NEW, 011 UPD)
//   vlr_o, alpha_o, rk_o, phi_o  held operands to RSA/NonLinear
module ekf_stage_seq #(
  parameter int              DW      = 32,
  parameter int              OBS_AW  = 3,
  parameter int              TO_W    = 20,
  parameter logic [TO_W-1:0] TIMEOUT = 20'hFFFFF
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              step_go,
  input  logic              prd_en,
  input  logic [DW-1:0]     vlr,
  input  logic [DW-1:0]     alpha,
  input  logic              obs_valid,
  output logic              obs_ready,
  input  logic [DW-1:0]     obs_rk,
  input  logic [DW-1:0]     obs_phi,
  input  logic              obs_new,
  output logic [OBS_AW:0]   obs_count,
  output logic              busy,
  output logic              step_done,
  output logic              err_timeout,
  output logic [2:0]        stage_val,
  input  logic              stage_rdy,
  output logic [DW-1:0]     vlr_o,
  output logic [DW-1:0]     alpha_o,
  output logic [DW-1:0]     rk_o,
  output logic [DW-1:0]     phi_o
);

  localparam int              DEPTH     = 1 << OBS_AW;
  localparam logic [OBS_AW:0] FULL_CNT  = {1'b1, {OBS_AW{1'b0}}};
  localparam logic [TO_W-1:0] WDOG_LAST = TIMEOUT - TO_W'(1);

  localparam logic [2:0] SV_IDLE = 3'b000;
  localparam logic [2:0] SV_PRD  = 3'b001;
  localparam logic [2:0] SV_NEW  = 3'b010;
  localparam logic [2:0] SV_UPD  = 3'b011;

  typedef enum logic [2:0] {S_IDLE, S_PRD, S_GAP, S_LOAD, S_OBS, S_DONE} state_e;

  typedef struct packed {
    logic [DW-1:0] rk;
    logic [DW-1:0] phi;
    logic          is_new;
  } obs_t;

  // ---------------- observation FIFO ----------------
  obs_t              mem_q [DEPTH];
  logic [OBS_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [OBS_AW:0]   count_q;
  logic              push, pop;
  obs_t              head;

  state_e state_q, state_d;

  assign obs_ready = (count_q != FULL_CNT);
  assign obs_count = count_q;
  assign push      = obs_valid & obs_ready;
  // The pop count never exceeds the step_go snapshot, so LOAD never sees an empty FIFO.
  assign pop       = (state_q == S_LOAD);
  assign head      = mem_q[rd_ptr_q];

  // NOTE: the storage array has no reset; a flush only clears the pointers and
  // the count, and stale entries are never read because count gates every pop.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{rk: obs_rk, phi: obs_phi, is_new: obs_new};
  end

  // NOTE: every sequential block uses non-blocking assignments, so all flops
  // sample values from before the clock edge and their order does not matter.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + OBS_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + OBS_AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (OBS_AW+1)'(1);
        2'b01:   count_q <= count_q - (OBS_AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------- step state machine ----------------
  logic [OBS_AW:0] remaining_q;
  logic [TO_W-1:0] wdog_q, wdog_d;
  logic            new_q, new_d;
  logic [2:0]      stage_val_q, stage_val_d;
  logic            busy_q, step_done_q, err_q;
  logic [DW-1:0]   vlr_q, alpha_q, rk_q, phi_q;
  logic            take_step, abort;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    take_step   = 1'b0;
    abort       = 1'b0;
    stage_val_d = SV_IDLE;

    case (state_q)
      S_IDLE: if (step_go) begin
        take_step = 1'b1;
        state_d   = prd_en ? S_PRD : S_GAP;
      end
      S_PRD, S_OBS: begin
        // stage_rdy takes priority over an expiring watchdog in the same cycle.
        if (stage_rdy) begin
          state_d = S_GAP;
        end else if (wdog_q == WDOG_LAST) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_GAP:   state_d = (remaining_q == '0) ? S_DONE : S_LOAD;
      S_LOAD:  state_d = S_OBS;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The stage type comes from the entry being popped, or is held once in OBS.
    new_d = (state_q == S_LOAD) ? head.is_new : new_q;

    // Outputs are decoded from the next state so they leave the flops aligned with it.
    case (state_d)
      S_PRD:   stage_val_d = SV_PRD;
      S_OBS:   stage_val_d = new_d ? SV_NEW : SV_UPD;
      default: stage_val_d = SV_IDLE;
    endcase

    // The watchdog restarts on entry to a stage and counts while the stage is held.
    wdog_d = ((state_d == S_PRD || state_d == S_OBS) && state_d == state_q)
             ? wdog_q + TO_W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      wdog_q      <= '0;
      new_q       <= 1'b0;
      stage_val_q <= SV_IDLE;
      busy_q      <= 1'b0;
      step_done_q <= 1'b0;
      err_q       <= 1'b0;
      vlr_q       <= '0;
      alpha_q     <= '0;
      rk_q        <= '0;
      phi_q       <= '0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      new_q       <= new_d;
      stage_val_q <= stage_val_d;
      busy_q      <= (state_d != S_IDLE);
      step_done_q <= (state_d == S_DONE);
      if (take_step) begin
        vlr_q       <= vlr;
        alpha_q     <= alpha;
        remaining_q <= count_q;   // Later pushes wait for the next step.
        err_q       <= 1'b0;
      end
      if (abort) err_q <= 1'b1;
      if (pop) begin
        rk_q        <= head.rk;
        phi_q       <= head.phi;
        remaining_q <= remaining_q - (OBS_AW+1)'(1);
      end
    end
  end

  assign stage_val   = stage_val_q;
  assign busy        = busy_q;
  assign step_done   = step_done_q;
  assign err_timeout = err_q;
  assign vlr_o       = vlr_q;
  assign alpha_o     = alpha_q;
  assign rk_o        = rk_q;
  assign phi_o       = phi_q;

endmodule

// File: tb/tb_ekf_stage_seq.sv
// Directed testbench for ekf_stage_seq. The watchdog is shortened to 16 cycles.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ekf_stage_seq;

  localparam int DW     = 32;
  localparam int OBS_AW = 3;

  logic              clk;
  logic              sys_rst;
  logic              step_go, prd_en;
  logic [DW-1:0]     vlr, alpha;
  logic              obs_valid, obs_ready;
  logic [DW-1:0]     obs_rk, obs_phi;
  logic              obs_new;
  logic [OBS_AW:0]   obs_count;
  logic              busy, step_done, err_timeout;
  logic [2:0]        stage_val;
  logic              stage_rdy;
  logic [DW-1:0]     vlr_o, alpha_o, rk_o, phi_o;

  int tests_run    = 0;
  int tests_failed = 0;

  ekf_stage_seq #(.DW(DW), .OBS_AW(OBS_AW), .TO_W(20), .TIMEOUT(20'd16)) dut (
    .clk(clk), .sys_rst(sys_rst), .step_go(step_go), .prd_en(prd_en),
    .vlr(vlr), .alpha(alpha), .obs_valid(obs_valid), .obs_ready(obs_ready),
    .obs_rk(obs_rk), .obs_phi(obs_phi), .obs_new(obs_new), .obs_count(obs_count),
    .busy(busy), .step_done(step_done), .err_timeout(err_timeout),
    .stage_val(stage_val), .stage_rdy(stage_rdy),
    .vlr_o(vlr_o), .alpha_o(alpha_o), .rk_o(rk_o), .phi_o(phi_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] rk, input logic [31:0] phi, input logic nw);
    obs_valid = 1'b1; obs_rk = rk; obs_phi = phi; obs_new = nw;
    @(negedge clk);
    obs_valid = 1'b0;
  endtask

  task automatic go(input logic pe, input logic [31:0] v, input logic [31:0] a);
    step_go = 1'b1; prd_en = pe; vlr = v; alpha = a;
    @(negedge clk);
    step_go = 1'b0;
  endtask

  // Called in the first cycle of a stage. Holds the stage for dly cycles, then
  // returns stage_rdy and ends in the following GAP cycle.
  task automatic serve(input string tag, input logic [2:0] exp_val, input bit chk_ops,
                       input logic [31:0] exp_rk, input logic [31:0] exp_phi, input int dly);
    int drops;
    check({tag, "_stage"}, 32'(stage_val), 32'(exp_val));
    if (chk_ops) begin
      check({tag, "_rk"},  rk_o,  exp_rk);
      check({tag, "_phi"}, phi_o, exp_phi);
    end
    drops = 0;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      if (stage_val !== exp_val) drops++;
    end
    if (dly > 0) check({tag, "_held"}, 32'(drops), 32'd0);
    stage_rdy = 1'b1;
    @(negedge clk);
    stage_rdy = 1'b0;
    check({tag, "_gap"}, {29'd0, stage_val}, 32'd0);
  endtask

  initial begin
    int n;
    bit done_seen;
    sys_rst = 1'b1; step_go = 1'b0; prd_en = 1'b0; vlr = '0; alpha = '0;
    obs_valid = 1'b0; obs_rk = '0; obs_phi = '0; obs_new = 1'b0; stage_rdy = 1'b0;
    repeat (3) @(negedge clk);
    sys_rst = 1'b0;

    // ---- reset state ----
    check("rst_stage_val", 32'(stage_val), 32'd0);
    check("rst_obs_ready", 32'(obs_ready), 32'd1);
    check("rst_obs_count", 32'(obs_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_step_done", 32'(step_done), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_vlr_o", vlr_o, 32'd0);

    // ---- full step: PRD, NEW, UPD ----
    push(32'd100, 32'd5, 1'b1);
    push(32'd200, 32'd7, 1'b0);
    check("t1_count2", 32'(obs_count), 32'd2);
    go(1'b1, 32'd3, 32'd4);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_vlr_o", vlr_o, 32'd3);
    check("t1_alpha_o", alpha_o, 32'd4);
    serve("t1_prd", 3'b001, 1'b0, 32'd0, 32'd0, 10);
    @(negedge clk);
    check("t1_load1", 32'(stage_val), 32'd0);
    @(negedge clk);
    serve("t1_new", 3'b010, 1'b1, 32'd100, 32'd5, 10);
    check("t1_gap_no_done", 32'(step_done), 32'd0);
    @(negedge clk);
    check("t1_load2", 32'(stage_val), 32'd0);
    @(negedge clk);
    serve("t1_upd", 3'b011, 1'b1, 32'd200, 32'd7, 10);
    @(negedge clk);
    check("t1_done", 32'(step_done), 32'd1);
    check("t1_done_stage", 32'(stage_val), 32'd0);
    @(negedge clk);
    check("t1_done_pulse", 32'(step_done), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_count0", 32'(obs_count), 32'd0);

    // ---- empty step, no PRD ----
    go(1'b0, 32'd9, 32'd9);
    check("t2_c1_busy", 32'(busy), 32'd1);
    check("t2_c1_done", 32'(step_done), 32'd0);
    check("t2_c1_stage", 32'(stage_val), 32'd0);
    @(negedge clk);
    check("t2_c2_done", 32'(step_done), 32'd1);
    check("t2_c2_busy", 32'(busy), 32'd1);
    check("t2_c2_stage", 32'(stage_val), 32'd0);
    @(negedge clk);
    check("t2_c3_done", 32'(step_done), 32'd0);
    check("t2_c3_busy", 32'(busy), 32'd0);

    // ---- FIFO full, overflow drop, push during LOAD ----
    for (int i = 0; i < 8; i++) begin
      check("t3_ready_before_push", 32'(obs_ready), 32'd1);
      push(32'(10 * (i + 1)), 32'(i + 1), (i % 2) == 0);
    end
    check("t3_full_ready", 32'(obs_ready), 32'd0);
    push(32'd90, 32'd9, 1'b1);
    check("t3_full_count", 32'(obs_count), 32'd8);
    go(1'b0, 32'd0, 32'd0);
    check("t3_gap0", 32'(stage_val), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t3_load", 32'(stage_val), 32'd0);
      if (i == 1) begin
        check("t3_load_count", 32'(obs_count), 32'd7);
        push(32'd999, 32'd9, 1'b1);
        check("t3_pushpop_count", 32'(obs_count), 32'd7);
      end else begin
        @(negedge clk);
      end
      serve("t3_obs", ((i % 2) == 0) ? 3'b010 : 3'b011, 1'b1,
            32'(10 * (i + 1)), 32'(i + 1), i % 3);
    end
    @(negedge clk);
    check("t3_done", 32'(step_done), 32'd1);
    check("t3_leftover", 32'(obs_count), 32'd1);
    @(negedge clk);

    // ---- watchdog abort in PRD ----
    go(1'b1, 32'd7, 32'd8);
    n = 0;
    done_seen = 1'b0;
    while (stage_val === 3'b001 && n < 40) begin
      n++;
      @(negedge clk);
      if (step_done === 1'b1) done_seen = 1'b1;
    end
    check("t4_prd_cycles", 32'(n), 32'd16);
    check("t4_stage_after", 32'(stage_val), 32'd0);
    check("t4_err", 32'(err_timeout), 32'd1);
    check("t4_no_done", 32'(done_seen), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_count", 32'(obs_count), 32'd1);
    @(negedge clk);
    check("t4_err_sticky", 32'(err_timeout), 32'd1);
    go(1'b0, 32'd1, 32'd2);
    check("t4_err_cleared", 32'(err_timeout), 32'd0);
    @(negedge clk);
    @(negedge clk);
    serve("t4_obs", 3'b010, 1'b1, 32'd999, 32'd9, 1);
    @(negedge clk);
    check("t4_done", 32'(step_done), 32'd1);
    @(negedge clk);
    check("t4_empty", 32'(obs_count), 32'd0);

    // ---- step_go while busy, reset during OBS ----
    push(32'd55, 32'd66, 1'b0);
    go(1'b1, 32'd11, 32'd12);
    step_go = 1'b1; prd_en = 1'b0; vlr = 32'd77;
    obs_valid = 1'b1; obs_rk = 32'd1; obs_phi = 32'd2; obs_new = 1'b1;
    @(negedge clk);
    step_go = 1'b0; obs_valid = 1'b0;
    check("t5_vlr_kept", vlr_o, 32'd11);
    check("t5_count2", 32'(obs_count), 32'd2);
    serve("t5_prd", 3'b001, 1'b0, 32'd0, 32'd0, 0);
    @(negedge clk);
    @(negedge clk);
    check("t5_obs_stage", 32'(stage_val), 32'd3);
    check("t5_obs_rk", rk_o, 32'd55);
    check("t5_obs_count", 32'(obs_count), 32'd1);
    sys_rst = 1'b1;
    @(negedge clk);
    sys_rst = 1'b0;
    check("t5_rst_stage", 32'(stage_val), 32'd0);
    check("t5_rst_count", 32'(obs_count), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_vlr", vlr_o, 32'd0);
    check("t5_rst_ready", 32'(obs_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ekf_stage_seq.md
Name: ekf_stage_seq

Overview:
- Step sequencer in front of the RSA/NonLinear pair.
- Accepts one motion command (vlr, alpha) and buffers observations (rk, phi, new/update flag) from the PS.
- On a step trigger it drives the RSA stage handshake in order: optional PRD, then one NEW or UPD stage per buffered observation.
- Presents held operands for each stage and reports completion or timeout, so the PS no longer hand-toggles stage_val.

Parameters:
DW, 32, operand width (vlr, alpha, rk, phi)
OBS_AW, 3, observation FIFO address width; depth = 2**OBS_AW = 8
TO_W, 20, width of the per-stage watchdog counter
TIMEOUT, 20'hFFFFF, cycles allowed in a stage before abort

Ports:
clk  in  1  system clock
sys_rst  in  1  synchronous active-high reset
step_go  in  1  single-cycle start-step pulse from PS
prd_en  in  1  sampled with step_go; 1 = run PRD first
vlr  in  DW  motion speed, sampled with step_go
alpha  in  DW  steering angle, sampled with step_go
obs_valid  in  1  observation push request
obs_ready  out  1  FIFO not full
obs_rk  in  DW  range
obs_phi  in  DW  bearing
obs_new  in  1  1 = NEW stage, 0 = UPD stage
obs_count  out  OBS_AW+1  current FIFO occupancy
busy  out  1  high when not IDLE
step_done  out  1  one-cycle pulse on normal completion
err_timeout  out  1  sticky watchdog flag
stage_val  out  3  to RSA: 000 idle, 001 PRD, 010 NEW, 011 UPD
stage_rdy  in  1  from RSA: stage complete
vlr_o  out  DW  held operand to RSA/NonLinear
alpha_o  out  DW  held operand to RSA/NonLinear
rk_o  out  DW  held operand to RSA/NonLinear
phi_o  out  DW  held operand to RSA/NonLinear

Behaviour:
Reset:
- All outputs 0; obs_ready=1; state IDLE; FIFO empty; counters 0.

FIFO:
- Synchronous, depth 8, first-word fall-through at head.
- Push when obs_valid & obs_ready; push while full is ignored.
- Push is accepted in any state.
- Pop only in LOAD.
- Push and pop in the same cycle: count unchanged, both take effect.

State machine (all outputs registered):
- IDLE: stage_val=000. step_go=1 → latch vlr_o/alpha_o, prd_en_r, remaining := obs_count (snapshot), clear err_timeout; go to PRD if prd_en, else to GAP.
  - step_go outside IDLE is ignored.
- PRD: stage_val=001 from the cycle after step_go (latency 1). Held until stage_rdy=1 sampled, then → GAP.
- GAP: stage_val=000 for exactly one cycle so RSA sees an IDLE edge.
  - remaining==0 → DONE; else → LOAD.
- LOAD: stage_val=000. Pop head into rk_o/phi_o/new_r; remaining -= 1. → OBS.
- OBS: stage_val = new_r ? 010 : 011. rk_o/phi_o valid in the same cycle stage_val leaves 000 and stable until the next LOAD. Held until stage_rdy=1, then → GAP.
- DONE: step_done=1 for one cycle, stage_val=000 → IDLE.

Step scope:
- Observations pushed after the step_go snapshot stay in the FIFO for the next step.
- prd_en=0 with remaining=0: IDLE→GAP→DONE; step_done 2 cycles after step_go; no stage issued.

Handshake rules:
- stage_rdy is ignored in IDLE/GAP/LOAD/DONE.
- stage_rdy in the same cycle the stage is first asserted counts as completion.

Watchdog:
- Counter cleared on entry to PRD/OBS, increments each cycle there.
- Reaches TIMEOUT without stage_rdy → err_timeout=1 (sticky), stage_val=000 next cycle, → IDLE.
- No step_done on abort. Unprocessed snapshot entries stay in the FIFO.
- err_timeout clears only on sys_rst or an accepted step_go.

Reset mid-operation:
- sys_rst in any state → IDLE next cycle, FIFO flushed, stage_val=000.

busy = (state != IDLE).

Test Plan:
- Reset, push 2 obs (rk=100, phi=5, new=1; rk=200, phi=7, new=0), step_go prd_en=1 vlr=3 alpha=4, RSA model asserts stage_rdy 10 cycles after each stage → stage_val sequence 001,000,000,010,000,000,011,000; rk_o=100 during 010, 200 during 011; step_done one pulse; obs_count=0.
- step_go prd_en=0 with empty FIFO → no nonzero stage_val; step_done exactly 2 cycles after step_go; busy high for 2 cycles.
- Fill FIFO with 9 pushes → obs_ready=0 after the 8th, 9th dropped, obs_count=8; during the step, push in the same cycle as LOAD pop → obs_count unchanged and new entry not processed in this step.
- TIMEOUT=16, RSA never asserts stage_rdy in PRD → stage_val=001 for 16 cycles then 000; err_timeout=1, no step_done, FIFO count unchanged; next step_go clears err_timeout.
- Assert step_go while busy → ignored (vlr_o unchanged); assert sys_rst during OBS → next cycle stage_val=000, obs_count=0, busy=0.
